pll_lock_supervisor: RTL and testbench

- Runs on the PLL reference clock and consumes the PLL `locked` output.
- Drives the PLL `rst` input.
- Sequences the downstream video-domain reset: holds `sys_rst_n` low until lock has been stable long enough.
- Resets and retries the PLL on lock timeout or lock loss, and reports a permanent failure after repeated timeouts.

---
 rtl/pll_sup_pkg.sv | 30 +++
 rtl/pll_lock_supervisor_sync_2ff.sv | 27 ++
 rtl/pll_lock_supervisor.sv | 130 +++++++++++++
 tb/tb_pll_lock_supervisor.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
// Holds the FSM state encoding, default timing constants and the timer-width helper.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } pll_state_e;

    localparam int unsigned DefPllRstCyc     = 16;
    localparam int unsigned DefLockTimeoutCyc = 50000;
    localparam int unsigned DefLockStableCyc = 1024;
    localparam int unsigned DefMaxRetries    = 4;
    localparam int unsigned DefLossCntW      = 8;

    // One spare bit above the largest count keeps the compare values representable.
    function automatic int unsigned timer_width(input int unsigned rst_cyc,
                                                input int unsigned timeout_cyc,
                                                input int unsigned stable_cyc);
        int unsigned max_cyc;
        max_cyc = rst_cyc;
        if (timeout_cyc > max_cyc) max_cyc = timeout_cyc;
        if (stable_cyc > max_cyc) max_cyc = stable_cyc;
        return $clog2(max_cyc) + 1;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Generic two-flop single-bit synchronizer with asynchronous active-low reset.
// Usable for any slow-changing level crossing into the clk_i domain.
module sync_2ff #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: drives the PLL reset, waits for a stable lock, then releases the
// downstream reset; retries on timeout or lock loss and latches a failure after repeated timeouts.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned PLL_RST_CYC      = DefPllRstCyc,
    parameter int unsigned LOCK_TIMEOUT_CYC = DefLockTimeoutCyc,
    parameter int unsigned LOCK_STABLE_CYC  = DefLockStableCyc,
    parameter int unsigned MAX_RETRIES      = DefMaxRetries,
    parameter int unsigned LOSS_CNT_W       = DefLossCntW
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  restart_req,
    output logic                  pll_rst,
    output logic                  sys_rst_n,
    output logic                  pll_fail,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
    output logic [2:0]            state_o
);

    localparam int unsigned TimerW = timer_width(PLL_RST_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);
    localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);

    localparam logic [TimerW-1:0] RstLast     = TimerW'(PLL_RST_CYC - 1);
    localparam logic [TimerW-1:0] TimeoutLast = TimerW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TimerW-1:0] StableLast  = TimerW'(LOCK_STABLE_CYC - 1);
    localparam logic [RetryW-1:0] RetryMax    = RetryW'(MAX_RETRIES);

    pll_state_e            state_q, state_d;
    logic [TimerW-1:0]     timer_q, timer_d;
    logic [RetryW-1:0]     retry_q, retry_d;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;
    logic                  locked_s;

    sync_2ff #(
        .ResetVal (1'b0)
    ) u_lock_sync (
        .clk_i  (refclk),
        .rst_ni (rst_n),
        .d_i    (pll_locked),
        .q_o    (locked_s)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        if (restart_req) begin
            state_d = S_PLL_RST;
            retry_d = '0;
        end else begin
            case (state_q)
                S_PLL_RST: begin
                    if (timer_q == RstLast) state_d = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = S_STABLE;
                    end else if (timer_q == TimeoutLast) begin
                        retry_d = retry_q + 1'b1;
                        state_d = (retry_d == RetryMax) ? S_FAIL : S_PLL_RST;
                    end
                end
                S_STABLE: begin
                    // A drop here is a settling glitch, not a failed attempt.
                    if (!locked_s) begin
                        state_d = S_WAIT_LOCK;
                    end else if (timer_q == StableLast) begin
                        state_d = S_RUN;
                        retry_d = '0;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state_d = S_PLL_RST;
                        if (loss_q != '1) loss_d = loss_q + 1'b1;
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d = S_PLL_RST;
                end
            endcase
        end
    end

    always_comb begin
        timer_d = timer_q + 1'b1;
        if (restart_req || (state_d != state_q)) begin
            timer_d = '0;
        end else if ((state_q == S_RUN) || (state_q == S_FAIL)) begin
            timer_d = timer_q;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_PLL_RST;
            timer_q <= '0;
            retry_q <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
        end
    end

    // Outputs decode the registered state only, so they are glitch-free and reset immediately.
    always_comb begin
        pll_rst       = 1'b0;
        sys_rst_n     = 1'b0;
        pll_fail      = 1'b0;
        lock_loss_cnt = loss_q;
        state_o       = state_q;
        case (state_q)
            S_PLL_RST: pll_rst   = 1'b1;
            S_RUN:     sys_rst_n = 1'b1;
            S_FAIL:    pll_fail  = 1'b1;
            default:   ;
        endcase
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural model.
module tb_pll_lock_supervisor;

    localparam int unsigned P_RST  = 4;
    localparam int unsigned P_TO   = 20;
    localparam int unsigned P_ST   = 8;
    localparam int unsigned P_MR   = 3;
    localparam int unsigned P_LW   = 8;

    logic            refclk = 1'b0;
    logic            rst_n = 1'b0;
    logic            pll_locked = 1'b0;
    logic            restart_req = 1'b0;
    logic            pll_rst;
    logic            sys_rst_n;
    logic            pll_fail;
    logic [P_LW-1:0] lock_loss_cnt;
    logic [2:0]      state_o;

    int checks = 0;
    int errors = 0;

    pll_lock_supervisor #(
        .PLL_RST_CYC      (P_RST),
        .LOCK_TIMEOUT_CYC (P_TO),
        .LOCK_STABLE_CYC  (P_ST),
        .MAX_RETRIES      (P_MR),
        .LOSS_CNT_W       (P_LW)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .restart_req   (restart_req),
        .pll_rst       (pll_rst),
        .sys_rst_n     (sys_rst_n),
        .pll_fail      (pll_fail),
        .lock_loss_cnt (lock_loss_cnt),
        .state_o       (state_o)
    );

    always #5 refclk = ~refclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack_outs(input int st, input logic r, input logic s,
                                              input logic f, input int loss);
        return {18'd0, 3'(st), r, s, f, 8'(loss)};
    endfunction

    function automatic logic [31:0] dut_outs();
        return {18'd0, state_o, pll_rst, sys_rst_n, pll_fail, lock_loss_cnt};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic wait_state(input int target, input int budget, input string name);
        int n = 0;
        while (state_o !== 3'(target) && n < budget) begin
            cyc(1);
            n++;
        end
        check(name, 32'(state_o), 32'(target));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pll_locked = 1'b0;
        restart_req = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    // Behavioural reference: countdown per phase, sync modelled as a two-sample delay.
    int m_phase, m_left, m_retries, m_loss;
    bit m_s1, m_s2;

    task automatic model_reset();
        m_phase = 0; m_left = P_RST; m_retries = 0; m_loss = 0; m_s1 = 0; m_s2 = 0;
    endtask

    task automatic model_step(input bit restart, input bit locked);
        bit ls;
        ls = m_s2;
        m_s2 = m_s1;
        m_s1 = locked;
        if (restart) begin
            m_phase = 0; m_left = P_RST; m_retries = 0;
        end else begin
            case (m_phase)
                0: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = 1; m_left = P_TO; end
                end
                1: begin
                    if (ls) begin
                        m_phase = 2; m_left = P_ST;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_retries++;
                            if (m_retries == P_MR) m_phase = 4;
                            else begin m_phase = 0; m_left = P_RST; end
                        end
                    end
                end
                2: begin
                    if (!ls) begin
                        m_phase = 1; m_left = P_TO;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin m_phase = 3; m_retries = 0; end
                    end
                end
                3: begin
                    if (!ls) begin
                        m_phase = 0; m_left = P_RST;
                        if (m_loss < 255) m_loss++;
                    end
                end
                default: ;
            endcase
        end
    endtask

    typedef struct {
        logic locked;
        logic restart;
        int   cycles;
        int   st;
        logic rst;
        logic sys;
        logic fail;
        int   loss;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int rises[$];
        int highs;
        logic prev;
        int exp_loss;
        int seg_left;

        vecs[0]  = '{1'b0, 1'b0, 3,  0, 1'b1, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b0, 1'b0, 1,  1, 1'b0, 1'b0, 1'b0, 0};
        vecs[2]  = '{1'b0, 1'b0, 5,  1, 1'b0, 1'b0, 1'b0, 0};
        vecs[3]  = '{1'b1, 1'b0, 10, 2, 1'b0, 1'b0, 1'b0, 0};
        vecs[4]  = '{1'b1, 1'b0, 1,  3, 1'b0, 1'b1, 1'b0, 0};
        vecs[5]  = '{1'b0, 1'b0, 2,  3, 1'b0, 1'b1, 1'b0, 0};
        vecs[6]  = '{1'b0, 1'b0, 1,  0, 1'b1, 1'b0, 1'b0, 1};
        vecs[7]  = '{1'b1, 1'b0, 3,  0, 1'b1, 1'b0, 1'b0, 1};
        vecs[8]  = '{1'b1, 1'b0, 1,  1, 1'b0, 1'b0, 1'b0, 1};
        vecs[9]  = '{1'b1, 1'b0, 1,  2, 1'b0, 1'b0, 1'b0, 1};
        vecs[10] = '{1'b1, 1'b0, 5,  2, 1'b0, 1'b0, 1'b0, 1};
        vecs[11] = '{1'b0, 1'b0, 3,  1, 1'b0, 1'b0, 1'b0, 1};
        vecs[12] = '{1'b1, 1'b0, 2,  1, 1'b0, 1'b0, 1'b0, 1};
        vecs[13] = '{1'b1, 1'b0, 1,  2, 1'b0, 1'b0, 1'b0, 1};
        vecs[14] = '{1'b1, 1'b0, 7,  2, 1'b0, 1'b0, 1'b0, 1};
        vecs[15] = '{1'b1, 1'b0, 1,  3, 1'b0, 1'b1, 1'b0, 1};

        // Bring-up, lock loss in RUN, glitch in STABLE.
        do_reset();
        check("reset_outs", dut_outs(), pack_outs(0, 1'b1, 1'b0, 1'b0, 0));
        for (int i = 0; i < 16; i++) begin
            pll_locked = vecs[i].locked;
            restart_req = vecs[i].restart;
            cyc(vecs[i].cycles);
            check($sformatf("vec%0d", i), dut_outs(),
                  pack_outs(vecs[i].st, vecs[i].rst, vecs[i].sys, vecs[i].fail, vecs[i].loss));
        end

        // Lock lost for good: one lock-loss reset then three timeouts into FAIL.
        pll_locked = 1'b0;
        highs = 0;
        prev = pll_rst;
        for (int i = 0; i < 200; i++) begin
            cyc(1);
            if (pll_rst) highs++;
            if (pll_rst && !prev) rises.push_back(i);
            prev = pll_rst;
            if (state_o == 3'd4) break;
        end
        check("to_pulses", 32'(rises.size()), 32'd3);
        check("to_high_cycles", 32'(highs), 32'd12);
        if (rises.size() == 3) begin
            check("to_spacing0", 32'(rises[1] - rises[0]), 32'(P_RST + P_TO));
            check("to_spacing1", 32'(rises[2] - rises[1]), 32'(P_RST + P_TO));
        end
        check("fail_outs", dut_outs(), pack_outs(4, 1'b0, 1'b0, 1'b1, 2));
        cyc(30);
        check("fail_hold", dut_outs(), pack_outs(4, 1'b0, 1'b0, 1'b1, 2));

        // Restart out of FAIL.
        restart_req = 1'b1;
        cyc(1);
        restart_req = 1'b0;
        check("restart_outs", dut_outs(), pack_outs(0, 1'b1, 1'b0, 1'b0, 2));
        cyc(3);
        check("restart_hold", 32'(state_o), 32'd0);
        cyc(1);
        check("restart_wait", 32'(state_o), 32'd1);
        pll_locked = 1'b1;
        wait_state(3, 40, "restart_run");
        check("restart_loss_kept", 32'(lock_loss_cnt), 32'd2);

        // Restart coinciding with the FSM seeing a lock drop in RUN: no loss count.
        pll_locked = 1'b0;
        cyc(2);
        check("coinc_pre", 32'(state_o), 32'd3);
        restart_req = 1'b1;
        cyc(1);
        restart_req = 1'b0;
        check("coinc_state", 32'(state_o), 32'd0);
        check("coinc_loss", 32'(lock_loss_cnt), 32'd2);
        pll_locked = 1'b1;
        wait_state(3, 60, "coinc_run");

        // Restart in PLL_RST restarts the full hold.
        pll_locked = 1'b0;
        wait_state(0, 10, "rr_drop");
        exp_loss = 3;
        cyc(2);
        restart_req = 1'b1;
        cyc(1);
        restart_req = 1'b0;
        cyc(3);
        check("rr_hold", 32'(state_o), 32'd0);
        cyc(1);
        check("rr_exit", 32'(state_o), 32'd1);
        pll_locked = 1'b1;
        wait_state(3, 40, "rr_run");

        // Saturating lock-loss counter.
        for (int k = 0; k < 260; k++) begin
            pll_locked = 1'b0;
            wait_state(0, 10, "sat_drop");
            exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
            check($sformatf("sat_loss%0d", k), 32'(lock_loss_cnt), 32'(exp_loss));
            pll_locked = 1'b1;
            wait_state(3, 60, "sat_run");
        end
        check("sat_final", 32'(lock_loss_cnt), 32'd255);

        // Asynchronous reset in the middle of STABLE, between clock edges.
        pll_locked = 1'b0;
        wait_state(0, 10, "ar_drop");
        pll_locked = 1'b1;
        wait_state(2, 30, "ar_stable");
        cyc(3);
        check("ar_pre", 32'(state_o), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_outs", dut_outs(), pack_outs(0, 1'b1, 1'b0, 1'b0, 0));

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        seg_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (seg_left == 0) begin
                if ($urandom_range(0, 19) == 0) begin
                    pll_locked = 1'b0;
                    seg_left = 120;
                end else begin
                    pll_locked = ($urandom_range(0, 9) < 7);
                    seg_left = $urandom_range(1, 60);
                end
            end
            seg_left--;
            restart_req = ($urandom_range(0, 149) == 0);
            @(posedge refclk);
            model_step(restart_req, pll_locked);
            #1;
            check("rand", dut_outs(),
                  pack_outs(m_phase, m_phase == 0, m_phase == 3, m_phase == 4, m_loss));
        end
        restart_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
